mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single unified memory port of the multi-cycle CPU. It shares the port between the CPU memory interface (instruction fetch and data access after the `i_or_d` select) and a DMA/loader requester. The memory has variable latency with a ready handshake, and the arbiter adds a response timeout. It sits between the CPU datapath, the DMA engine and the memory model; it is the only master that drives the memory.

---
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter/sequencer for the unified memory port
// Optional build macro ARB_FIXED_PRIORITY_EN: CPU always wins a tie, last_gnt frozen at reset value.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_done,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_done,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int              CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   CNT_MAX  = {CW{1'b1}};
  localparam logic            GNT_CPU  = 1'b0;
  localparam logic            GNT_DMA  = 1'b1;

  state_t        state;
  state_t        state_nxt;
  logic          owner;
  logic          last_gnt;
  logic          err_q;
  logic [CW-1:0] cnt;
  logic          any_req;
  logic          pick_dma;
  logic          timed_out;

  always_comb begin
    any_req = cpu_req | dma_req;
`ifdef ARB_FIXED_PRIORITY_EN
    pick_dma = dma_req & ~cpu_req;
`else
    pick_dma = dma_req & (~cpu_req | (last_gnt == GNT_CPU));
`endif
    timed_out = (cnt >= CNT_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (mem_ready || timed_out) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode only flops, so nothing ripples from inputs to outputs.
  always_comb begin
    mem_valid = (state == BUSY);
    cpu_gnt   = (state != IDLE) && (owner == GNT_CPU);
    dma_gnt   = (state != IDLE) && (owner == GNT_DMA);
    cpu_done  = (state == DONE) && (owner == GNT_CPU);
    dma_done  = (state == DONE) && (owner == GNT_DMA);
    err       = (state == DONE) && err_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= GNT_CPU;
      last_gnt  <= GNT_DMA;
      err_q     <= 1'b0;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= pick_dma;
`ifndef ARB_FIXED_PRIORITY_EN
            last_gnt <= pick_dma;
`endif
            err_q     <= 1'b0;
            cnt       <= '0;
            mem_we    <= pick_dma ? dma_we    : cpu_we;
            mem_addr  <= pick_dma ? dma_addr  : cpu_addr;
            mem_wdata <= pick_dma ? dma_wdata : cpu_wdata;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            err_q <= 1'b0;
            if (owner == GNT_DMA) dma_rdata <= mem_we ? '0 : mem_rdata;
            else                  cpu_rdata <= mem_we ? '0 : mem_rdata;
          end else if (timed_out) begin
            err_q <= 1'b1;
            if (owner == GNT_DMA) dma_rdata <= '0;
            else                  cpu_rdata <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, cpu_done, dma_gnt, dma_done;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_valid, mem_we, mem_ready, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int vcnt;
  logic addr_bad;
  logic exp_dma2;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef ARB_FIXED_PRIORITY_EN
    exp_dma2 = 1'b0;
`else
    exp_dma2 = 1'b1;
`endif
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    tick(); tick();
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_dma_gnt", dma_gnt, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    reset = 1'b1;
    tick();

    // CPU-only read, ready on first BUSY cycle
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    tick();
    chk("a_cpu_gnt", cpu_gnt, 1);
    chk("a_mem_valid", mem_valid, 1);
    chk("a_mem_addr", mem_addr, 32'h100);
    chk("a_mem_we", mem_we, 0);
    chk("a_dma_gnt", dma_gnt, 0);
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("a_cpu_done", cpu_done, 1);
    chk("a_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("a_err", err, 0);
    chk("a_mem_valid_done", mem_valid, 0);
    chk("a_dma_done", dma_done, 0);
    chk("a_dma_rdata", dma_rdata, 0);
    mem_ready = 0; cpu_req = 0;
    tick();
    chk("a_idle_gnt", cpu_gnt, 0);
    chk("a_idle_done", cpu_done, 0);

    // Fresh reset so the tie starts with the CPU
    reset = 1'b0; tick(); reset = 1'b1; tick();

    // Both requesters, writes, zero wait, ready held high throughout
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h11111111;
    dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h22222222;
    mem_ready = 1; mem_rdata = 32'h55AA55AA;
    tick();
    chk("b1_cpu_gnt", cpu_gnt, 1);
    chk("b1_mem_addr", mem_addr, 32'h10);
    chk("b1_mem_we", mem_we, 1);
    chk("b1_mem_wdata", mem_wdata, 32'h11111111);
    tick();
    chk("b1_cpu_done", cpu_done, 1);
    chk("b1_cpu_rdata", cpu_rdata, 0);
    tick();
    chk("b1_idle_valid", mem_valid, 0);
    chk("b1_idle_gnt", cpu_gnt | dma_gnt, 0);
    tick();
    chk("b2_dma_gnt", dma_gnt, exp_dma2);
    chk("b2_cpu_gnt", cpu_gnt, !exp_dma2);
    chk("b2_mem_addr", mem_addr, exp_dma2 ? 32'h20 : 32'h10);
    tick();
    chk("b2_dma_done", dma_done, exp_dma2);
    chk("b2_cpu_done", cpu_done, !exp_dma2);
    chk("b2_dma_rdata", dma_rdata, 0);
    tick();
    tick();
    chk("b3_cpu_gnt", cpu_gnt, 1);
    chk("b3_mem_wdata", mem_wdata, 32'h11111111);
    tick();
    chk("b3_cpu_done", cpu_done, 1);
    cpu_req = 0; dma_req = 0; mem_ready = 0;
    cpu_we = 0; dma_we = 0;
    tick();

    // DMA read, ready arrives on the 5th BUSY cycle
    dma_req = 1; dma_addr = 32'h300;
    tick();
    vcnt = 0; addr_bad = 0;
    for (int i = 1; i <= 5; i++) begin
      if (mem_valid) vcnt++;
      if (mem_addr !== 32'h300) addr_bad = 1;
      if (i == 5) begin mem_ready = 1; mem_rdata = 32'hCAFEF00D; end
      tick();
    end
    chk("c_valid_cycles", vcnt, 5);
    chk("c_addr_stable", addr_bad, 0);
    chk("c_dma_done", dma_done, 1);
    chk("c_dma_rdata", dma_rdata, 32'hCAFEF00D);
    chk("c_err", err, 0);
    chk("c_mem_valid", mem_valid, 0);
    dma_req = 0; mem_ready = 0;
    tick();

    // Timeout with ready tied low
    cpu_req = 1; cpu_addr = 32'h400;
    tick();
    vcnt = 0;
    while (mem_valid && vcnt < 40) begin
      vcnt++;
      tick();
    end
    chk("d_valid_cycles", vcnt, 16);
    chk("d_cpu_done", cpu_done, 1);
    chk("d_err", err, 1);
    chk("d_cpu_rdata", cpu_rdata, 0);
    cpu_req = 0;
    tick();
    chk("d_idle_err", err, 0);
    chk("d_idle_gnt", cpu_gnt, 0);

    // Reset during the 3rd BUSY cycle
    cpu_req = 1; cpu_addr = 32'h600;
    tick(); tick(); tick();
    chk("e_busy_valid", mem_valid, 1);
    reset = 1'b0;
    #1;
    chk("e_rst_valid", mem_valid, 0);
    chk("e_rst_gnt", cpu_gnt, 0);
    dma_req = 1; dma_addr = 32'h700;
    tick();
    chk("e_rst_done", cpu_done, 0);
    reset = 1'b1;
    tick();
    chk("e_tie_cpu_gnt", cpu_gnt, 1);
    chk("e_tie_dma_gnt", dma_gnt, 0);
    mem_ready = 1; mem_rdata = 32'h0BADF00D;
    tick();
    chk("e_cpu_done", cpu_done, 1);
    cpu_req = 0; dma_req = 0; mem_ready = 0;
    tick();

    // Request withdrawn during BUSY still completes, no regrant
    cpu_req = 1; cpu_addr = 32'h500;
    tick();
    chk("f_cpu_gnt", cpu_gnt, 1);
    cpu_req = 0;
    tick();
    mem_ready = 1; mem_rdata = 32'h12345678;
    tick();
    chk("f_cpu_done", cpu_done, 1);
    chk("f_cpu_rdata", cpu_rdata, 32'h12345678);
    mem_ready = 0;
    tick();
    tick();
    chk("f_no_regrant", cpu_gnt, 0);
    chk("f_no_valid", mem_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
